// File: rtl/uart_rx_param_if.sv
// Output handshake bundle of the UART receiver: received payload, error flags and valid/ready.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;
  logic                 m_parity_err;
  logic                 m_frame_err;

  modport master (
    output m_data,
    output m_valid,
    output m_parity_err,
    output m_frame_err,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    input  m_parity_err,
    input  m_frame_err,
    output m_ready
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: oversampled 3-sample majority bit recovery, optional parity,
// 1 or 2 stop bits, false-start rejection and an overrun-flagging valid/ready output register.
module uart_rx_param #(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  uart_rx_param_if.master m,
  output logic            overrun,
  output logic            busy
);
  localparam int DIV   = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int T_W   = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [T_W-1:0]   T_S0     = T_W'(OVERSAMPLE / 2 - 1);
  localparam logic [T_W-1:0]   T_S1     = T_W'(OVERSAMPLE / 2);
  localparam logic [T_W-1:0]   T_DEC    = T_W'(OVERSAMPLE / 2 + 1);
  localparam logic [T_W-1:0]   T_LAST   = T_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t               state;
  state_t               state_next;
  logic                 rx_meta;
  logic                 rxs;
  logic [DIV_W-1:0]     div_cnt;
  logic [T_W-1:0]       t;
  logic                 s0;
  logic                 s1;
  logic [DATA_BITS-1:0] data;
  logic [IDX_W-1:0]     bit_idx;
  logic                 stop_idx;
  logic                 perr;
  logic                 ferr;
  logic                 commit_pend;
  logic [DATA_BITS-1:0] out_data;
  logic                 out_valid;
  logic                 out_perr;
  logic                 out_ferr;

  logic tick;
  logic decide;
  logic bit_end;
  logic decision;
  logic last_stop;
  logic parity_exp;
  logic start_frame;
  logic commit_set;

  // The divider only runs outside IDLE, so it restarts from zero on every start edge.
  assign tick       = (state != S_IDLE) && (div_cnt == DIV_LAST);
  assign decide     = tick && (t == T_DEC);
  assign bit_end    = tick && (t == T_LAST);
  assign decision   = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
  assign last_stop  = (STOP_BITS == 2) ? stop_idx : 1'b1;
  assign parity_exp = (PARITY == 2) ? ^data : ~^data;

  assign busy           = (state != S_IDLE);
  assign m.m_data       = out_data;
  assign m.m_valid      = out_valid;
  assign m.m_parity_err = out_perr;
  assign m.m_frame_err  = out_ferr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    start_frame = 1'b0;
    commit_set  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rxs) begin
          state_next  = S_START;
          start_frame = 1'b1;
        end
      end
      S_START: begin
        if (decide && decision) state_next = S_IDLE;
        else if (bit_end)       state_next = S_DATA;
      end
      S_DATA: begin
        if (bit_end && (bit_idx == IDX_LAST))
          state_next = (PARITY != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (bit_end) state_next = S_STOP;
      end
      // The frame is committed at the last stop decision, without waiting for the bit end.
      S_STOP: begin
        if (decide && last_stop) begin
          commit_set = 1'b1;
          state_next = (ferr || !decision) ? S_BREAK : S_IDLE;
        end
      end
      S_BREAK: begin
        if (tick && rxs) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta     <= 1'b1;
      rxs         <= 1'b1;
      div_cnt     <= '0;
      t           <= '0;
      s0          <= 1'b1;
      s1          <= 1'b1;
      data        <= '0;
      bit_idx     <= '0;
      stop_idx    <= 1'b0;
      perr        <= 1'b0;
      ferr        <= 1'b0;
      commit_pend <= 1'b0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_perr    <= 1'b0;
      out_ferr    <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;

      if (state == S_IDLE) begin
        div_cnt <= '0;
        t       <= '0;
      end else if (tick) begin
        div_cnt <= '0;
        t       <= (t == T_LAST) ? '0 : t + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      if (tick && (t == T_S0)) s0 <= rxs;
      if (tick && (t == T_S1)) s1 <= rxs;

      if (start_frame) begin
        data     <= '0;
        bit_idx  <= '0;
        stop_idx <= 1'b0;
        perr     <= 1'b0;
        ferr     <= 1'b0;
      end

      if (state == S_DATA) begin
        if (decide)  data[bit_idx] <= decision;
        if (bit_end) bit_idx <= bit_idx + 1'b1;
      end

      if ((state == S_PARITY) && decide) perr <= (decision != parity_exp);

      if (state == S_STOP) begin
        if (decide && !decision) ferr <= 1'b1;
        if (bit_end)             stop_idx <= 1'b1;
      end

      // A commit always wins over a same-cycle consume; a full, unconsumed register drops the frame.
      commit_pend <= commit_set;
      overrun     <= 1'b0;
      if (commit_pend) begin
        if (!out_valid || m.m_ready) begin
          out_data  <= data;
          out_perr  <= perr;
          out_ferr  <= ferr;
          out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && m.m_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_param.sv
// Randomised bench for uart_rx_param: an 8N1 instance and an 8E2 instance, checked against a frame-level model.
module tb_uart_rx_param;
  localparam int BIT_CLKS = 16;

  logic clk;
  logic reset;
  logic rx_a;
  logic rx_b;
  logic overrun_a;
  logic overrun_b;
  logic busy_a;
  logic busy_b;

  uart_rx_param_if #(.DATA_BITS(8)) ifa ();
  uart_rx_param_if #(.DATA_BITS(8)) ifb ();

  uart_rx_param #(
    .CLOCK_FREQ(1_600_000), .BAUD_RATE(100_000), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
  ) dut_a (
    .clk(clk), .reset(reset), .rx(rx_a), .m(ifa), .overrun(overrun_a), .busy(busy_a)
  );

  uart_rx_param #(
    .CLOCK_FREQ(1_600_000), .BAUD_RATE(100_000), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)
  ) dut_b (
    .clk(clk), .reset(reset), .rx(rx_b), .m(ifb), .overrun(overrun_b), .busy(busy_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int ovr_a    = 0;
  int ovr_b    = 0;

  // Each entry is {data, parity_err, frame_err}.
  logic [9:0] exp_a[$];
  logic [9:0] exp_b[$];
  logic [9:0] got_a[$];
  logic [9:0] got_b[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ifa.m_valid && ifa.m_ready) got_a.push_back({ifa.m_data, ifa.m_parity_err, ifa.m_frame_err});
    if (ifb.m_valid && ifb.m_ready) got_b.push_back({ifb.m_data, ifb.m_parity_err, ifb.m_frame_err});
    if (overrun_a) ovr_a++;
    if (overrun_b) ovr_b++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_line(input bit which, input bit v, input int n);
    if (which) rx_b = v;
    else       rx_a = v;
    tick_clk(n);
  endtask

  // Sends one frame followed by two idle bit times and records what the model expects back.
  task automatic applyStimulus(input bit which, input logic [7:0] d, input bit pbit,
                               input bit st1, input bit st2);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (which) begin
      bits.push_back(pbit);
      bits.push_back(st1);
      bits.push_back(st2);
    end else begin
      bits.push_back(st1);
    end
    foreach (bits[i]) drive_line(which, bits[i], BIT_CLKS);
    drive_line(which, 1'b1, 2 * BIT_CLKS);
    if (which) exp_b.push_back({d, (($countones(d) + int'(pbit)) % 2) != 0, !(st1 && st2)});
    else       exp_a.push_back({d, 1'b0, !st1});
  endtask

  task automatic check_frames(input bit which, input string tag);
    int ng;
    int ne;
    logic [9:0] g;
    logic [9:0] e;
    ng = which ? got_b.size() : got_a.size();
    ne = which ? exp_b.size() : exp_a.size();
    checkOutput({tag, " frame count"}, ng, ne);
    for (int i = 0; i < ((ng < ne) ? ng : ne); i++) begin
      g = which ? got_b[i] : got_a[i];
      e = which ? exp_b[i] : exp_a[i];
      checkOutput({tag, " data"}, g[9:2], e[9:2]);
      checkOutput({tag, " parity_err"}, g[1], e[1]);
      checkOutput({tag, " frame_err"}, g[0], e[0]);
    end
    if (which) begin
      got_b.delete();
      exp_b.delete();
    end else begin
      got_a.delete();
      exp_a.delete();
    end
  endtask

  initial begin
    logic [7:0] d;
    bit pb;
    int ovr_base;
    reset = 1'b1;
    rx_a = 1'b1;
    rx_b = 1'b1;
    ifa.m_ready = 1'b1;
    ifb.m_ready = 1'b1;
    tick_clk(3);
    checkOutput("reset m_valid", ifa.m_valid, 0);
    checkOutput("reset m_data", ifa.m_data, 0);
    checkOutput("reset perr", ifa.m_parity_err, 0);
    checkOutput("reset ferr", ifa.m_frame_err, 0);
    checkOutput("reset busy", busy_a, 0);
    checkOutput("reset overrun", overrun_a, 0);
    reset = 1'b0;
    tick_clk(4);

    applyStimulus(1'b0, 8'hA5, 1'b0, 1'b1, 1'b1);
    check_frames(1'b0, "8N1 0xA5");
    checkOutput("8N1 busy after frame", busy_a, 0);

    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom_range(0, 255));
      applyStimulus(1'b0, d, 1'b0, ($urandom_range(0, 3) != 0), 1'b1);
      check_frames(1'b0, "8N1 random");
    end

    applyStimulus(1'b1, 8'h03, 1'b1, 1'b1, 1'b1);
    check_frames(1'b1, "8E2 0x03 bad parity");

    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom_range(0, 255));
      pb = ($countones(d) % 2 != 0) ^ ($urandom_range(0, 2) == 0);
      applyStimulus(1'b1, d, pb, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
      check_frames(1'b1, "8E2 random");
    end

    // Short glitch: start rejected at the majority decision, nothing delivered.
    drive_line(1'b0, 1'b0, 4);
    drive_line(1'b0, 1'b1, 2);
    checkOutput("glitch busy during start", busy_a, 1);
    tick_clk(14);
    checkOutput("glitch busy cleared", busy_a, 0);
    tick_clk(30);
    check_frames(1'b0, "glitch");

    drive_line(1'b0, 1'b0, 20 * BIT_CLKS);
    exp_a.push_back({8'h00, 1'b0, 1'b1});
    checkOutput("break busy while low", busy_a, 1);
    drive_line(1'b0, 1'b1, 3 * BIT_CLKS);
    check_frames(1'b0, "break");
    applyStimulus(1'b0, 8'h5A, 1'b0, 1'b1, 1'b1);
    check_frames(1'b0, "after break 0x5A");

    ifa.m_ready = 1'b0;
    ovr_base = ovr_a;
    applyStimulus(1'b0, 8'h11, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 8'h22, 1'b0, 1'b1, 1'b1);
    void'(exp_a.pop_back());
    checkOutput("overrun m_valid held", ifa.m_valid, 1);
    checkOutput("overrun m_data kept", ifa.m_data, 8'h11);
    checkOutput("overrun pulse count", ovr_a - ovr_base, 1);
    ifa.m_ready = 1'b1;
    tick_clk(1);
    ifa.m_ready = 1'b0;
    checkOutput("overrun m_valid drop", ifa.m_valid, 0);
    check_frames(1'b0, "overrun accepted");
    ifa.m_ready = 1'b1;

    ifb.m_ready = 1'b0;
    applyStimulus(1'b1, 8'h3C, 1'b0, 1'b1, 1'b0);
    exp_b.delete();
    checkOutput("2nd stop m_valid", ifb.m_valid, 1);
    checkOutput("2nd stop m_data", ifb.m_data, 8'h3C);
    checkOutput("2nd stop perr", ifb.m_parity_err, 0);
    checkOutput("2nd stop ferr", ifb.m_frame_err, 1);
    drive_line(1'b1, 1'b0, BIT_CLKS);
    drive_line(1'b1, 1'b1, BIT_CLKS);
    drive_line(1'b1, 1'b0, BIT_CLKS / 2);
    checkOutput("mid-frame busy", busy_b, 1);
    reset = 1'b1;
    tick_clk(2);
    checkOutput("mid reset m_valid", ifb.m_valid, 0);
    checkOutput("mid reset m_data", ifb.m_data, 0);
    checkOutput("mid reset ferr", ifb.m_frame_err, 0);
    checkOutput("mid reset perr", ifb.m_parity_err, 0);
    checkOutput("mid reset busy", busy_b, 0);
    rx_b = 1'b1;
    reset = 1'b0;
    ifb.m_ready = 1'b1;
    tick_clk(3 * BIT_CLKS);
    checkOutput("after reset busy", busy_b, 0);
    applyStimulus(1'b1, 8'hC3, 1'b0, 1'b1, 1'b1);
    check_frames(1'b1, "after reset 0xC3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
